// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if : requester-side and memory-bus-side signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_grant;
  logic              if_done;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_grant;
  logic              ls_done;

  logic [DATA_W-1:0] rdata;
  logic              timeout_err;

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_mode;
  logic              bus_start_transaction;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rdata_valid;
  logic              bus_write_done;

  // Arbiter view
  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
           bus_rdata, bus_rdata_valid, bus_write_done,
    output if_grant, if_done, ls_grant, ls_done, rdata, timeout_err,
           bus_addr, bus_wdata, bus_mode, bus_start_transaction
  );

  // Requester / memory view
  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
           bus_rdata, bus_rdata_valid, bus_write_done,
    input  if_grant, if_done, ls_grant, ls_done, rdata, timeout_err,
           bus_addr, bus_wdata, bus_mode, bus_start_transaction
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter : round-robin fetch/load-store arbiter and bus sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  wire                logic clk,
  input  wire                logic rst_n,
  mem_bus_arbiter_if.master  bus_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic             OWN_IF       = 1'b0;
  localparam logic             OWN_LS       = 1'b1;
  localparam int               CNT_W        = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic w_pick_ls;
  logic w_complete;
  logic w_active;
  logic w_release;

  // On a tie the requester that did not own the bus last time wins
  assign w_pick_ls  = bus_if.ls_req && (!bus_if.if_req || last_owner_q == OWN_IF);
  assign w_complete = mode_q ? bus_if.bus_write_done : bus_if.bus_rdata_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;
      mode_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mode_d       = mode_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus_if.if_req || bus_if.ls_req) begin
          owner_d = w_pick_ls;
          state_d = S_ISSUE;
          if (w_pick_ls) begin
            addr_d  = bus_if.ls_addr;
            wdata_d = bus_if.ls_wdata;
            mode_d  = bus_if.ls_we;
          end else begin
            addr_d  = bus_if.if_addr;
            mode_d  = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the final allowed cycle still beats the timeout
        if (w_complete) begin
          if (!mode_q) begin
            rdata_d = bus_if.bus_rdata;
          end
          err_d   = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_active  = (state_q != S_IDLE);
  assign w_release = (state_q == S_RELEASE);

  assign bus_if.if_grant              = w_active && (owner_q == OWN_IF);
  assign bus_if.ls_grant              = w_active && (owner_q == OWN_LS);
  assign bus_if.if_done               = w_release && !err_q && (owner_q == OWN_IF);
  assign bus_if.ls_done               = w_release && !err_q && (owner_q == OWN_LS);
  assign bus_if.timeout_err           = w_release && err_q;
  assign bus_if.bus_start_transaction = (state_q == S_ISSUE);
  assign bus_if.bus_addr              = addr_q;
  assign bus_if.bus_wdata             = wdata_q;
  assign bus_if.bus_mode              = mode_q;
  assign bus_if.rdata                 = rdata_q;

endmodule
`default_nettype wire
